mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage access unit sitting directly upstream of the 4 KiB word-addressed data memory (word port: 10-bit word address, 32-bit din/dout, single write-enable, combinational read).
- Converts pipeline load/store requests (word, halfword, byte) into word-granular memory operations.
- Sub-word stores run as a two-cycle read-modify-write, stalling the pipeline for one cycle.
- Sub-word loads are extracted and sign/zero-extended; misaligned or out-of-range accesses are flagged and suppressed.

Parameters:
- DM_AW, 12, byte-address width of the data memory; word address is addr[DM_AW-1:2].
- DEFAULT_RDATA, 32'h0000_0000, rdata value when no load is active or on fault.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_rd  input  1  load request this cycle.
- mem_wr  input  1  store request this cycle (mem_rd and mem_wr both high is treated as fault).
- size  input  2  00 byte, 01 half, 10 word, 11 illegal (fault).
- ld_unsigned  input  1  1: zero-extend sub-word load; 0: sign-extend.
- addr  input  32  byte address from ALU.
- wdata  input  32  store data; byte/half taken from low bits.
- dm_dout  input  32  word read from data memory (combinational).
- dm_addr  output  DM_AW-2  word address to data memory.
- dm_din  output  32  write data to data memory.
- dm_we  output  1  data memory write enable.
- rdata  output  32  extended load result to MEM/WB.
- stall  output  1  hold IF/ID/EX/MEM stages.
- fault  output  1  access error (misaligned, out of range, illegal size, rd&wr).
- rmw_cnt  output  16  number of completed sub-word RMW writes, wraps at 16'hFFFF -> 0.

Behaviour:
- Byte lanes are little-endian: addr[1:0]=0 selects dm bits [7:0]; a half at addr[1]=1 selects bits [31:16].
- fault (combinational, IDLE only):
  - a request (mem_rd|mem_wr) with size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:DM_AW]!=0;
  - mem_rd&mem_wr.
- On fault: dm_we=0, rdata=DEFAULT_RDATA, stall=0, no state change.
- FSM states: IDLE, MERGE. Reset state: IDLE.
- Reset values (held while rst=1):
  - state=IDLE, latched addr/wdata/size cleared, rmw_cnt=0;
  - outputs dm_we=0, stall=0, fault=0, rdata=DEFAULT_RDATA;
  - dm_addr=0, dm_din=0.
- IDLE, load (no fault):
  - dm_addr=addr[DM_AW-1:2];
  - rdata = selected lane of dm_dout, extended per ld_unsigned;
  - 0 added latency, stall=0.
- IDLE, word store (no fault): dm_addr=addr word, dm_din=wdata, dm_we=1 in the same cycle, stall=0.
- IDLE, byte/half store (no fault):
  - dm_addr=addr word, dm_we=0, stall=1;
  - at posedge: latch dm_dout into merge_q, latch addr word, byte offset, size, wdata; go MERGE.
- MERGE:
  - dm_addr=latched word address;
  - dm_din=merge_q with the target lane(s) replaced by wdata[7:0] or wdata[15:0]; dm_we=1;
  - stall=0, fault=0, rdata=DEFAULT_RDATA;
  - live inputs ignored this cycle;
  - at posedge: rmw_cnt+=1, go IDLE.
- Pipeline contract: while stall=1 the request inputs are held stable. The request is then seen again in MERGE and ignored, so it executes exactly once.
- No request (mem_rd=mem_wr=0) in IDLE: dm_we=0, rdata=DEFAULT_RDATA, dm_addr=addr word (don't-care read).
- Reset asserted in MERGE: the write is dropped (dm_we forced 0 asynchronously), state returns to IDLE, and rmw_cnt is not incremented.
- Back-to-back sub-word stores: IDLE->MERGE->IDLE->MERGE, i.e. 2 cycles each.
- A load immediately after MERGE reads the already-written word, because the memory write has committed at that edge.

Test Plan:
- Reset: assert rst mid-cycle with mem_wr=1 -> dm_we=0, stall=0, rmw_cnt=0 immediately; state IDLE after release.
- Word store addr=0x0000_0010, wdata=0xDEADBEEF, size=10 -> same cycle dm_addr=4, dm_din=0xDEADBEEF, dm_we=1, stall=0; rmw_cnt unchanged.
- Byte store addr=0x12, wdata=0x000000AA, dm word 4 = 0x11223344:
  - cycle 1: stall=1, dm_we=0;
  - cycle 2: dm_din=0x11AA3344, dm_we=1;
  - rmw_cnt=1.
- Loads from word 0x8000F0FF at addr 0x20:
  - lb (signed), addr 0x20 -> rdata=0xFFFFFFFF;
  - lbu, addr 0x21 -> 0x000000F0;
  - lh, addr 0x22 -> 0xFFFF8000;
  - lhu, addr 0x22 -> 0x00008000.
- Faults:
  - sw addr=0x16 -> fault=1, dm_we=0;
  - sh addr=0x13 -> fault=1, no stall;
  - lw addr=0x0000_1000 -> fault=1, rdata=0.
- Reset during MERGE of sh addr=0x30: dm_we never pulses, word 0x30 unchanged, rmw_cnt=0; the next sb completes normally with rmw_cnt=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : MEM-stage load/store front end for a word-addressed DMEM
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int          DM_AW         = 12,
  parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [1:0]      size,
  input  logic            ld_unsigned,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic [31:0]     dm_dout,
  output logic [DM_AW-3:0] dm_addr,
  output logic [31:0]     dm_din,
  output logic            dm_we,
  output logic [31:0]     rdata,
  output logic            stall,
  output logic            fault,
  output logic [15:0]     rmw_cnt
);

  localparam int WAW = DM_AW - 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  state_t         state;
  logic [31:0]    merge_q;
  logic [15:0]    wdata_q;
  logic [WAW-1:0] waddr_q;
  logic [1:0]     boff_q;
  logic           half_q;
  logic [15:0]    cnt_q;

  logic           w_req;
  logic           w_oor;
  logic           w_misalign;
  logic           w_bad;
  logic           w_idle;
  logic           w_ok_ld;
  logic           w_st_word;
  logic           w_st_sub;
  logic [7:0]     w_lane_b;
  logic [15:0]    w_lane_h;
  logic [31:0]    w_load_val;
  logic [31:0]    w_merged;

  assign w_req      = mem_rd | mem_wr;
  assign w_oor      = |addr[31:DM_AW];
  assign w_misalign = ((size == SZ_HALF) & addr[0]) |
                      ((size == SZ_WORD) & (|addr[1:0]));
  assign w_bad      = (mem_rd & mem_wr) |
                      (w_req & ((size == SZ_ILL) | w_misalign | w_oor));
  assign w_idle     = (state == IDLE);
  assign w_ok_ld    = w_idle & mem_rd & ~w_bad;
  assign w_st_word  = w_idle & mem_wr & ~w_bad & (size == SZ_WORD);
  assign w_st_sub   = w_idle & mem_wr & ~w_bad & (size != SZ_WORD);

  // Little-endian lane pick for loads
  assign w_lane_b = dm_dout[{addr[1:0], 3'b000} +: 8];
  assign w_lane_h = addr[1] ? dm_dout[31:16] : dm_dout[15:0];

  always_comb begin
    w_load_val = dm_dout;
    case (size)
      SZ_BYTE: w_load_val = {{24{~ld_unsigned & w_lane_b[7]}}, w_lane_b};
      SZ_HALF: w_load_val = {{16{~ld_unsigned & w_lane_h[15]}}, w_lane_h};
      default: w_load_val = dm_dout;
    endcase
  end

  // Splice the latched store data into the word captured on the first cycle
  always_comb begin
    w_merged = merge_q;
    if (half_q) begin
      w_merged[{boff_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      w_merged[{boff_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Outputs are combinational; rst overrides them so an interrupted merge never writes
  always_comb begin
    dm_addr = '0;
    dm_din  = '0;
    dm_we   = 1'b0;
    rdata   = DEFAULT_RDATA;
    stall   = 1'b0;
    fault   = 1'b0;
    if (!rst) begin
      if (state == MERGE) begin
        dm_addr = waddr_q;
        dm_din  = w_merged;
        dm_we   = 1'b1;
      end else begin
        dm_addr = addr[DM_AW-1:2];
        dm_din  = wdata;
        dm_we   = w_st_word;
        stall   = w_st_sub;
        fault   = w_bad;
        if (w_ok_ld) begin
          rdata = w_load_val;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      merge_q <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      boff_q  <= '0;
      half_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (w_st_sub) begin
            merge_q <= dm_dout;
            wdata_q <= wdata[15:0];
            waddr_q <= addr[DM_AW-1:2];
            boff_q  <= addr[1:0];
            half_q  <= (size == SZ_HALF);
            state   <= MERGE;
          end
        end
        MERGE: begin
          cnt_q <= cnt_q + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rmw_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit : directed + random bench with a byte-array memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr, ld_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata, dm_dout, dm_din, rdata;
  logic [9:0]  dm_addr;
  logic        dm_we, stall, fault;
  logic [15:0] rmw_cnt;

  logic [31:0] mem [0:1023];
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  logic [7:0]  refb [0:4095];
  int          exp_cnt;
  int          checks;
  int          failures;

  mem_access_unit #(.DM_AW(12), .DEFAULT_RDATA(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size),
    .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata), .dm_dout(dm_dout),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .rdata(rdata),
    .stall(stall), .fault(fault), .rmw_cnt(rmw_cnt)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge, backdoor for preload
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_din;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
  endfunction

  task automatic txn(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic        flt;
    int          nb;
    logic [31:0] erd;
    nb  = 1 << sz;
    flt = (rd || wr) && (sz == 2'd3 || (a % nb) != 0 || a >= 32'd4096 || (rd && wr));
    erd = 32'h0;
    if (!flt && rd) begin
      for (int i = 0; i < nb; i++) erd |= 32'(refb[a+i]) << (8*i);
      if (!uns && nb < 4 && erd[8*nb-1]) erd |= ~((32'h1 << (8*nb)) - 32'h1);
    end
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; size = sz; ld_unsigned = uns; addr = a; wdata = wd;
    #1;
    got = rdata;
    check("fault", 32'(fault), 32'(flt));
    check("rdata", rdata, erd);
    check("we", 32'(dm_we), 32'(!flt && wr && sz == 2'd2));
    check("stall", 32'(stall), 32'(!flt && wr && sz < 2'd2));
    if (!flt) check("addr", 32'(dm_addr), (a % 32'd4096) / 32'd4);
    if (!flt && wr && sz == 2'd2) check("din", dm_din, wd);
    if (!flt && wr) for (int i = 0; i < nb; i++) refb[a+i] = wd[8*i +: 8];
    @(posedge clk);
    if (!flt && wr && sz < 2'd2) begin
      @(negedge clk);
      #1;
      check("m_we", 32'(dm_we), 32'd1);
      check("m_stall", 32'(stall), 32'd0);
      check("m_fault", 32'(fault), 32'd0);
      check("m_rdata", rdata, 32'h0);
      check("m_addr", 32'(dm_addr), a / 32'd4);
      check("m_din", dm_din, ref_word(int'(a / 32'd4)));
      exp_cnt = (exp_cnt + 1) % 65536;
      @(posedge clk);
    end
    #1;
    check("cnt", 32'(rmw_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, v, a;
    logic [1:0]  sz;
    int          k;
    checks = 0; failures = 0; exp_cnt = 0;
    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    mem_rd = 0; mem_wr = 0; size = 0; ld_unsigned = 0; addr = 0; wdata = 0;

    for (int w = 0; w < 1024; w++) begin
      v = (w == 4) ? 32'h1122_3344 : (w == 8) ? 32'h8000_F0FF : $urandom;
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 10'(w); bd_data = v;
      for (int b = 0; b < 4; b++) refb[4*w+b] = v[8*b +: 8];
    end
    @(negedge clk);
    bd_we = 1'b0;

    // Outputs held at reset values even with a live store request
    mem_wr = 1; size = 2'd2; addr = 32'h10; wdata = 32'h1;
    #1;
    check("rst_we", 32'(dm_we), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", 32'(dm_addr), 0);
    check("rst_din", dm_din, 0);
    check("rst_cnt", 32'(rmw_cnt), 0);
    @(negedge clk);
    mem_wr = 0; rst = 1'b0;

    txn(0, 1, 2'd0, 0, 32'h12, 32'h0000_00AA, got);
    check("sb_word", mem[4], 32'h11AA_3344);
    check("sb_cnt", 32'(rmw_cnt), 32'd1);
    txn(0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, got);
    check("sw_word", mem[4], 32'hDEAD_BEEF);
    txn(1, 0, 2'd0, 0, 32'h20, 32'h0, got); check("lb", got, 32'hFFFF_FFFF);
    txn(1, 0, 2'd0, 1, 32'h21, 32'h0, got); check("lbu", got, 32'h0000_00F0);
    txn(1, 0, 2'd1, 0, 32'h22, 32'h0, got); check("lh", got, 32'hFFFF_8000);
    txn(1, 0, 2'd1, 1, 32'h22, 32'h0, got); check("lhu", got, 32'h0000_8000);
    txn(0, 1, 2'd2, 0, 32'h16, 32'h1234_5678, got);
    txn(0, 1, 2'd1, 0, 32'h13, 32'h1234_5678, got);
    txn(1, 0, 2'd2, 0, 32'h1000, 32'h0, got); check("lw_oor", got, 32'h0);
    txn(1, 1, 2'd2, 0, 32'h40, 32'h0, got);
    txn(1, 0, 2'd3, 0, 32'h40, 32'h0, got);

    // Asynchronous reset mid-cycle kills a word store and clears the counter
    @(negedge clk);
    mem_rd = 0; mem_wr = 1; size = 2'd2; addr = 32'h40; wdata = 32'hCAFE_F00D;
    #1 check("pre_rst_we", 32'(dm_we), 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(dm_we), 0);
    check("mid_rst_stall", 32'(stall), 0);
    check("mid_rst_cnt", 32'(rmw_cnt), 0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0; mem_wr = 0;
    #1 check("mid_rst_mem", mem[16], ref_word(16));

    // Reset while the merge write is pending
    txn(0, 1, 2'd0, 0, 32'h31, 32'h77, got);
    @(negedge clk);
    mem_rd = 0; mem_wr = 1; size = 2'd1; addr = 32'h30; wdata = 32'h5555;
    #1 check("mrg_stall", 32'(stall), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mrg_rst_we", 32'(dm_we), 0);
    check("mrg_rst_cnt", 32'(rmw_cnt), 0);
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_wr = 0;
    #1;
    check("mrg_rst_mem", mem[12], ref_word(12));
    check("mrg_rst_idle", 32'(stall), 0);
    txn(0, 1, 2'd0, 0, 32'h32, 32'h99, got);
    check("after_rst_cnt", 32'(rmw_cnt), 32'd1);

    // Back-to-back sub-word stores
    txn(0, 1, 2'd1, 0, 32'h50, 32'hBEEF, got);
    txn(0, 1, 2'd0, 0, 32'h53, 32'hC3, got);
    txn(1, 0, 2'd2, 0, 32'h50, 32'h0, got);

    for (int n = 0; n < 600; n++) begin
      k  = $urandom_range(0, 9);
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 19))
        0:       a = $urandom;
        1:       a = $urandom_range(4088, 4095);
        default: a = $urandom_range(0, 127);
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      txn((k < 4) || (k == 8), (k >= 4 && k <= 8), sz, 1'($urandom_range(0, 1)),
          a, $urandom, got);
    end

    for (int w = 0; w < 1024; w++) check("mem", mem[w], ref_word(w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
